ifu_fetch: RTL and testbench

Instruction fetch unit: owns the architectural fetch PC, issues single-outstanding requests to the instruction memory port and presents each fetched instruction with its PC and static branch prediction to the IF/ID pipeline register. Sits directly upstream of the IF/ID register; honours that register's stall and the execute-stage redirect (flush).

---
 rtl/ifu_fetch.sv | 176 +++++++++++++++++
 tb/tb_ifu_fetch.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the fetch PC, keeps one memory request in flight and
// presents fetched instructions to IF/ID. Optional static branch prediction: IFU_BPU_EN.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module ifu_fetch #(
  parameter logic [`PC_WIDTH-1:0]    RESET_PC  = 32'h0000_0000,
  parameter logic [`INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_i,
  input  logic                    flush_i,
  input  logic [`PC_WIDTH-1:0]    flush_pc_i,
  output logic                    ifu_req_o,
  output logic [`PC_WIDTH-1:0]    ifu_addr_o,
  input  logic                    ifu_gnt_i,
  input  logic                    ifu_rvalid_i,
  input  logic [`INSTR_WIDTH-1:0] ifu_rdata_i,
  output logic                    if_valid_o,
  output logic [`PC_WIDTH-1:0]    if_pc_o,
  output logic [`INSTR_WIDTH-1:0] if_instr_o,
  output logic                    if_prdt_taken_o
);

  localparam int PW = `PC_WIDTH;
  localparam int IW = `INSTR_WIDTH;
  localparam logic [PW-1:0] PC_INC = PW'(3'd4);

  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISCARD = 2'd3
  } state_e;

  state_e          state_r, state_nxt_s;
  logic [PW-1:0]   pc_r, pc_nxt_s;
  logic [IW-1:0]   hold_instr_r;
  logic [PW-1:0]   hold_pc_r;
  logic            hold_prdt_r;
  logic            capture_s;
  logic            rsp_taken_s;
  logic [PW-1:0]   rsp_npc_s, hold_npc_s;
  logic            req_s, valid_s, prdt_s;
  logic [PW-1:0]   addr_s, pc_out_s;
  logic [IW-1:0]   instr_s;

`ifdef IFU_BPU_EN
  function automatic logic bpu_taken(input logic [IW-1:0] instr);
    bpu_taken = (instr[6:0] == 7'b1101111) ||
                ((instr[6:0] == 7'b1100011) && instr[31]);
  endfunction

  function automatic logic [PW-1:0] bpu_imm(input logic [IW-1:0] instr);
    if (instr[6:0] == 7'b1101111) begin
      bpu_imm = PW'({{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0});
    end else begin
      bpu_imm = PW'({{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0});
    end
  endfunction

  assign rsp_taken_s = bpu_taken(ifu_rdata_i);
  assign rsp_npc_s   = rsp_taken_s ? pc_r + bpu_imm(ifu_rdata_i) : pc_r + PC_INC;
  assign hold_npc_s  = hold_prdt_r ? hold_pc_r + bpu_imm(hold_instr_r) : hold_pc_r + PC_INC;
`else
  assign rsp_taken_s = 1'b0;
  assign rsp_npc_s   = pc_r + PC_INC;
  assign hold_npc_s  = hold_pc_r + PC_INC;
`endif

  // Next-state, next-pc and port values for the fetch FSM; flush outranks everything.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    capture_s   = 1'b0;
    req_s       = 1'b0;
    addr_s      = pc_r;
    valid_s     = 1'b0;
    pc_out_s    = pc_r;
    instr_s     = NOP_INSTR;
    prdt_s      = 1'b0;
    case (state_r)
      ST_REQ: begin
        if (flush_i) begin
          pc_nxt_s    = flush_pc_i;
          state_nxt_s = ST_REQ;
        end else begin
          req_s       = 1'b1;
          state_nxt_s = ifu_gnt_i ? ST_WAIT : ST_REQ;
        end
      end
      ST_WAIT: begin
        if (flush_i) begin
          pc_nxt_s    = flush_pc_i;
          state_nxt_s = ifu_rvalid_i ? ST_REQ : ST_DISCARD;
        end else if (ifu_rvalid_i) begin
          valid_s = 1'b1;
          instr_s = ifu_rdata_i;
          prdt_s  = rsp_taken_s;
          if (!stall_i) begin
            // Consumed: the follow-on request goes out in the same cycle.
            pc_nxt_s    = rsp_npc_s;
            req_s       = 1'b1;
            addr_s      = rsp_npc_s;
            state_nxt_s = ifu_gnt_i ? ST_WAIT : ST_REQ;
          end else begin
            capture_s   = 1'b1;
            state_nxt_s = ST_HOLD;
          end
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (flush_i) begin
          pc_nxt_s    = flush_pc_i;
          state_nxt_s = ST_REQ;
        end else begin
          valid_s  = 1'b1;
          pc_out_s = hold_pc_r;
          instr_s  = hold_instr_r;
          prdt_s   = hold_prdt_r;
          if (!stall_i) begin
            pc_nxt_s    = hold_npc_s;
            state_nxt_s = ST_REQ;
          end else begin
            state_nxt_s = ST_HOLD;
          end
        end
      end
      ST_DISCARD: begin
        if (flush_i) begin
          pc_nxt_s = flush_pc_i;
        end else begin
          pc_nxt_s = pc_r;
        end
        state_nxt_s = ifu_rvalid_i ? ST_REQ : ST_DISCARD;
      end
      default: begin
        state_nxt_s = ST_REQ;
      end
    endcase
  end

  // State, fetch PC and hold buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_REQ;
      pc_r         <= RESET_PC;
      hold_instr_r <= NOP_INSTR;
      hold_pc_r    <= RESET_PC;
      hold_prdt_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      if (capture_s) begin
        hold_instr_r <= ifu_rdata_i;
        hold_pc_r    <= pc_r;
        hold_prdt_r  <= rsp_taken_s;
      end
    end
  end

  assign ifu_req_o       = rst ? 1'b0 : req_s;
  assign ifu_addr_o      = rst ? RESET_PC : addr_s;
  assign if_valid_o      = rst ? 1'b0 : valid_s;
  assign if_pc_o         = rst ? RESET_PC : pc_out_s;
  assign if_instr_o      = rst ? NOP_INSTR : instr_s;
  assign if_prdt_taken_o = rst ? 1'b0 : prdt_s;

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: expected request addresses and presented
// instructions are queued by the stimulus and popped by negedge monitors.
`timescale 1ns/1ps
module tb_ifu_fetch;

`ifdef IFU_BPU_EN
  localparam bit BPU_ON = 1'b1;
`else
  localparam bit BPU_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_pc_i = 32'h0;
  logic        ifu_req_o;
  logic [31:0] ifu_addr_o;
  logic        ifu_gnt_i;
  logic        ifu_rvalid_i;
  logic [31:0] ifu_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        if_prdt_taken_o;

  ifu_fetch #(.RESET_PC(32'h0000_0100), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .ifu_req_o(ifu_req_o), .ifu_addr_o(ifu_addr_o), .ifu_gnt_i(ifu_gnt_i),
    .ifu_rvalid_i(ifu_rvalid_i), .ifu_rdata_i(ifu_rdata_i),
    .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_instr_o(if_instr_o),
    .if_prdt_taken_o(if_prdt_taken_o)
  );

  always #5 clk = ~clk;

  // Memory model: grant follows request while enabled, response after lat cycles.
  logic [31:0] mem [int unsigned];
  logic        gnt_en = 1'b1;
  int          lat = 1;
  logic        pend;
  int          cnt;
  logic [31:0] pdata;

  function automatic logic [31:0] lookup(input logic [31:0] a);
    lookup = mem.exists(a) ? mem[a] : 32'h0000_0013;
  endfunction

  assign ifu_gnt_i    = ifu_req_o & gnt_en;
  assign ifu_rvalid_i = pend && (cnt == 0);
  assign ifu_rdata_i  = pdata;

  always @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
      cnt  <= 0;
    end else begin
      if (pend && cnt != 0) cnt <= cnt - 1;
      if (pend && cnt == 0) pend <= 1'b0;
      if (ifu_req_o && ifu_gnt_i) begin
        pend  <= 1'b1;
        cnt   <= lat - 1;
        pdata <= lookup(ifu_addr_o);
      end
    end
  end

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        prdt;
  } out_t;

  logic [31:0] addr_q [$];
  out_t        out_q [$];
  int          n_vec = 0;
  int          n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_vec++;
    n_miss++;
    $display("FAIL %s: got transfer %08h expected none", name, act);
  endtask

  task automatic push_out(input logic [31:0] pc, input logic [31:0] instr, input logic prdt);
    out_t e;
    e.pc = pc; e.instr = instr; e.prdt = prdt;
    out_q.push_back(e);
  endtask

  // Monitors: every granted request and every presented instruction pops one entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (ifu_req_o && ifu_gnt_i) begin
        if (addr_q.size() == 0) unexpected("req_addr", ifu_addr_o);
        else check("req_addr", ifu_addr_o, addr_q.pop_front());
      end
      if (if_valid_o) begin
        if (out_q.size() == 0) unexpected("out_pc", if_pc_o);
        else begin
          out_t e;
          e = out_q.pop_front();
          check("out_pc", if_pc_o, e.pc);
          check("out_instr", if_instr_o, e.instr);
          check("out_prdt", {31'd0, if_prdt_taken_o}, {31'd0, e.prdt});
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; flush_pc_i = 32'h0;
    gnt_en = 1'b1; lat = 1;
    @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'd0, ifu_req_o}, 32'd0);
    check("rst_addr", ifu_addr_o, 32'h100);
    check("rst_valid", {31'd0, if_valid_o}, 32'd0);
    check("rst_instr", if_instr_o, 32'h13);
    check("rst_pc", if_pc_o, 32'h100);
    check("rst_prdt", {31'd0, if_prdt_taken_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) cyc();
    check("addr_q_left", addr_q.size(), 32'd0);
    check("out_q_left", out_q.size(), 32'd0);
    addr_q.delete();
    out_q.delete();
  endtask

  task automatic idle_checks(input string name);
    @(negedge clk);
    check({name, "_valid"}, {31'd0, if_valid_o}, 32'd0);
    check({name, "_req"}, {31'd0, ifu_req_o}, 32'd0);
  endtask

  // Redirect to pc, fetch instr there, then one fetch at the expected next pc.
  task automatic fetch_one(input logic [31:0] pc, input logic [31:0] instr,
                           input logic prdt, input logic [31:0] npc);
    mem[pc] = instr;
    do_reset();
    addr_q.push_back(pc); addr_q.push_back(npc);
    push_out(pc, instr, prdt); push_out(npc, 32'h13, 1'b0);
    flush_i = 1'b1; flush_pc_i = pc;
    cyc(); flush_i = 1'b0;
    cyc();
    cyc(); gnt_en = 1'b0;
    drain(3);
  endtask

  initial begin
    // Zero-wait streaming from RESET_PC
    do_reset();
    addr_q.push_back(32'h100); addr_q.push_back(32'h104); addr_q.push_back(32'h108);
    push_out(32'h100, 32'h13, 1'b0); push_out(32'h104, 32'h13, 1'b0);
    push_out(32'h108, 32'h13, 1'b0);
    @(negedge clk); check("stream_c1_valid", {31'd0, if_valid_o}, 32'd0);
    cyc();
    @(negedge clk); check("stream_c2_valid", {31'd0, if_valid_o}, 32'd1);
    cyc();
    cyc(); gnt_en = 1'b0;
    drain(3);

    // Stall held three cycles while the response at 0x200 is presented
    mem[32'h200] = 32'h00A0_0093;
    do_reset();
    addr_q.push_back(32'h200); addr_q.push_back(32'h204);
    for (int i = 0; i < 4; i++) push_out(32'h200, 32'h00A0_0093, 1'b0);
    push_out(32'h204, 32'h13, 1'b0);
    flush_i = 1'b1; flush_pc_i = 32'h200;
    idle_checks("stall_redir");
    cyc(); flush_i = 1'b0;
    cyc(); stall_i = 1'b1;
    cyc(); @(negedge clk); check("stall_c4_req", {31'd0, ifu_req_o}, 32'd0);
    cyc(); @(negedge clk); check("stall_c5_req", {31'd0, ifu_req_o}, 32'd0);
    cyc(); stall_i = 1'b0;
    @(negedge clk); check("stall_c6_req", {31'd0, ifu_req_o}, 32'd0);
    cyc();
    cyc(); gnt_en = 1'b0;
    drain(3);

    // Flush in WAIT before the response: late response must be dropped
    do_reset();
    lat = 3;
    addr_q.push_back(32'h100); addr_q.push_back(32'h400);
    push_out(32'h400, 32'h13, 1'b0);
    cyc(); flush_i = 1'b1; flush_pc_i = 32'h400;
    idle_checks("disc_c2");
    cyc(); flush_i = 1'b0;
    idle_checks("disc_c3");
    cyc();
    idle_checks("disc_c4");
    cyc();
    cyc(); gnt_en = 1'b0;
    drain(5);

    // Flush and stall together while holding
    do_reset();
    addr_q.push_back(32'h100); addr_q.push_back(32'h500);
    push_out(32'h100, 32'h13, 1'b0); push_out(32'h500, 32'h13, 1'b0);
    cyc(); stall_i = 1'b1;
    cyc(); flush_i = 1'b1; flush_pc_i = 32'h500;
    idle_checks("holdflush");
    cyc(); flush_i = 1'b0; stall_i = 1'b0;
    cyc(); gnt_en = 1'b0;
    drain(3);

    // Static prediction cases
    fetch_one(32'h300, 32'hFE00_0EE3, BPU_ON, BPU_ON ? 32'h0000_02FC : 32'h0000_0304);
    fetch_one(32'hFFFF_FFFC, 32'h0080_006F, BPU_ON, BPU_ON ? 32'h0000_0004 : 32'h0000_0000);
    fetch_one(32'h300, 32'h0000_0463, 1'b0, 32'h0000_0304);
    fetch_one(32'h600, 32'h0000_80E7, 1'b0, 32'h0000_0604);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
